mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multi-cycle control unit that drives the existing MIPS datapath's control inputs from the OPCODE/FUNC it returns.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Emits one-cycle pc_en/ir_en/RegWrite/MemWrite strobes and holds mux selects stable.
- Counts retired instructions and flags unsupported encodings.

Parameters:
- COUNT_WIDTH, 32, width of instr_count (wraps modulo 2^COUNT_WIDTH).
- STICKY_ILLEGAL, 1: 1 = illegal stays set until reset; 0 = one-cycle pulse.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- OPCODE  in  6  instr[31:26] from datapath
- FUNC  in  6  instr[5:0] from datapath
- ir_en  out  1  instruction register load strobe
- pc_en  out  1  PC update strobe
- RegDst  out  3  0=rd 1=rt 2=$31
- NPCop  out  3  0=PC+4 1=beq 2=j/jal 3=jr
- MemToReg  out  3  0=ALU 1=DM 2=PC+4
- RegWrite  out  1  GRF write strobe
- MemWrite  out  1  DM write strobe
- ALUSrc  out  3  0=RD2 1=Extout
- Extop  out  2  0=zero-ext 1=sign-ext 2=imm<<16
- ALUop  out  2  0=addu 1=subu 2=or
- state  out  3  current state, for debug
- instr_count  out  COUNT_WIDTH  retired instructions
- illegal  out  1  unsupported instruction seen

Behaviour:
- Reset (async, any state): state=FETCH; all strobes, selects, instr_count and illegal = 0. Reset mid-instruction aborts it; no RegWrite/MemWrite/pc_en may fire while reset is high or in the cycle it deasserts.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 go to FETCH.
- FETCH: ir_en=1 for one cycle; goes to DECODE.
- DECODE: latch OPCODE/FUNC into an internal class register; later states use only the latched class. Goes to EXEC, or back to FETCH if illegal.
- Supported instructions (opcode/func, binary):
  - addu 000000/100001, subu 000000/100011, jr 000000/001000, nop 000000/000000
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011
- State sequences (cycles per instruction):
  - R-type, ori, lui: F,D,E,W (4)
  - lw: F,D,E,M,W (5)
  - sw: F,D,E,M (4)
  - beq, j, jal, jr, nop: F,D,E (3)
  - illegal: F,D (2)
- Final state of each instruction:
  - pc_en=1 for exactly one cycle, with NPCop per class (beq=1, j/jal=2, jr=3, otherwise 0).
  - instr_count increments in the same cycle.
  - Next state is FETCH.
- RegWrite: one cycle, in the final state only, for addu/subu/ori/lui/lw/jal.
- MemWrite: one cycle, in MEM, for sw only.
- Per-class selects, held from EXEC through the final state (0 elsewhere):
  - addu/subu: RegDst=0, ALUSrc=0, ALUop=0/1, MemToReg=0
  - ori: RegDst=1, ALUSrc=1, Extop=0, ALUop=2, MemToReg=0
  - lui: RegDst=1, ALUSrc=1, Extop=2, ALUop=2, MemToReg=0 (rs=$0 by encoding)
  - lw/sw: ALUSrc=1, Extop=1, ALUop=0; lw also RegDst=1, MemToReg=1
  - beq: ALUSrc=0, ALUop=1
  - jal: RegDst=2, MemToReg=2 (PC not yet updated, so PC+4 is correct)
- Illegal instruction:
  - illegal is set in the cycle after DECODE (sticky or one-cycle pulse per STICKY_ILLEGAL).
  - pc_en=1 with NPCop=0 in DECODE, so the PC skips the instruction.
  - instr_count does not increment.
- instr_count wraps from all-ones to 0 with no flag.
- All outputs are registered or decoded purely from registered state: no combinational path from OPCODE/FUNC to any output.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state codes and opcode/func constants
  - mux-select encodings for RegDst, NPCop, MemToReg, ALUSrc, Extop, ALUop
  - the instruction-class enum: RTYPE_ADDU, RTYPE_SUBU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, NOP, ILL
- One natural sub-module, mc_instr_decode: combinational OPCODE/FUNC to class. The FSM instantiates it and latches its output in DECODE.

Test Plan:
- Reset asserted mid-EXEC of lw (OPCODE=100011) -> state=0 and all strobes 0 immediately, asynchronously; after release, FETCH with ir_en=1 on the first edge.
- addu (000000/100001) -> states 0,1,2,4; in WB RegWrite=1, RegDst=0, ALUop=0, MemToReg=0, pc_en=1, NPCop=0; instr_count 0->1.
- lw then sw -> lw takes 5 cycles with RegWrite only in WB, MemToReg=1, Extop=1; sw takes 4 cycles with MemWrite=1 only in MEM, RegWrite never asserted.
- jal (000011) -> 3 cycles; in EXEC RegWrite=1, RegDst=2, MemToReg=2, pc_en=1, NPCop=2.
- Illegal OPCODE=111111 -> 2 cycles, illegal=1, pc_en=1 with NPCop=0 in DECODE, instr_count unchanged; with STICKY_ILLEGAL=1 illegal stays 1 after a following addu.
- COUNT_WIDTH=4, execute 16 nops (48 cycles) -> instr_count wraps 15->0; pc_en pulses exactly 16 times.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes, instruction
// encodings, datapath mux-select encodings and the instruction-class enum.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    RTYPE_ADDU,
    RTYPE_SUBU,
    ORI,
    LUI,
    LW,
    SW,
    BEQ,
    J,
    JAL,
    JR,
    NOP,
    ILL
  } instr_class_e;

  // instr[31:26]
  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSw      = 6'b101011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;

  // instr[5:0] under OpSpecial
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnNop  = 6'b000000;

  localparam logic [2:0] RegDstRd = 3'd0;
  localparam logic [2:0] RegDstRt = 3'd1;
  localparam logic [2:0] RegDstRa = 3'd2;

  localparam logic [2:0] NpcPc4  = 3'd0;
  localparam logic [2:0] NpcBeq  = 3'd1;
  localparam logic [2:0] NpcJump = 3'd2;
  localparam logic [2:0] NpcJr   = 3'd3;

  localparam logic [2:0] MemToRegAlu = 3'd0;
  localparam logic [2:0] MemToRegDm  = 3'd1;
  localparam logic [2:0] MemToRegPc4 = 3'd2;

  localparam logic [2:0] AluSrcRd2 = 3'd0;
  localparam logic [2:0] AluSrcExt = 3'd1;

  localparam logic [1:0] ExtZero = 2'd0;
  localparam logic [1:0] ExtSign = 2'd1;
  localparam logic [1:0] ExtLui  = 2'd2;

  localparam logic [1:0] AluAddu = 2'd0;
  localparam logic [1:0] AluSubu = 2'd1;
  localparam logic [1:0] AluOr   = 2'd2;

  // Last state an instruction of this class occupies before returning to FETCH.
  function automatic state_e final_state(input instr_class_e cls);
    state_e st;
    case (cls)
      ILL:                           st = StDecode;
      SW:                            st = StMem;
      RTYPE_ADDU, RTYPE_SUBU, ORI,
      LUI, LW:                       st = StWb;
      default:                       st = StExec;
    endcase
    return st;
  endfunction

  function automatic logic writes_reg(input instr_class_e cls);
    return cls inside {RTYPE_ADDU, RTYPE_SUBU, ORI, LUI, LW, JAL};
  endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational classifier: maps the OPCODE/FUNC fields of the current instruction
// onto one instruction class; anything unsupported becomes ILL.
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   func_i,
  output instr_class_e class_o
);

  always_comb begin
    class_o = ILL;
    case (opcode_i)
      OpSpecial: begin
        case (func_i)
          FnAddu:  class_o = RTYPE_ADDU;
          FnSubu:  class_o = RTYPE_SUBU;
          FnJr:    class_o = JR;
          FnNop:   class_o = NOP;
          default: class_o = ILL;
        endcase
      end
      OpOri:   class_o = ORI;
      OpLui:   class_o = LUI;
      OpLw:    class_o = LW;
      OpSw:    class_o = SW;
      OpBeq:   class_o = BEQ;
      OpJ:     class_o = J;
      OpJal:   class_o = JAL;
      default: class_o = ILL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the MIPS datapath. Every output is decoded from registered
// state only, so nothing combinational reaches the outputs from OPCODE/FUNC.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter bit          STICKY_ILLEGAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OPCODE,
  input  logic [5:0]             FUNC,
  output logic                   ir_en,
  output logic                   pc_en,
  output logic [2:0]             RegDst,
  output logic [2:0]             NPCop,
  output logic [2:0]             MemToReg,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic [2:0]             ALUSrc,
  output logic [1:0]             Extop,
  output logic [1:0]             ALUop,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   illegal
);

  state_e                 state_q, state_d;
  instr_class_e           cls_q, cls_d;
  instr_class_e           dec_cls;
  logic                   run_q, run_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   illegal_q, illegal_d;
  logic                   final_cyc;
  logic                   sel_active;
  logic                   ill_decode;

  mc_instr_decode u_decode (
    .opcode_i (OPCODE),
    .func_i   (FUNC),
    .class_o  (dec_cls)
  );

  // run_q holds the machine idle for the first edge after reset so no strobe can fire
  // while reset is high or in the cycle it is released.
  assign final_cyc  = run_q && (state_q != StFetch) && (state_q == final_state(cls_q));
  assign sel_active = run_q && (state_q inside {StExec, StMem, StWb});
  assign ill_decode = run_q && (state_q == StDecode) && (cls_q == ILL);

  always_comb begin
    run_d   = 1'b1;
    state_d = state_q;
    cls_d   = cls_q;
    if (!run_q) begin
      state_d = StFetch;
    end else begin
      case (state_q)
        StFetch: begin
          // Capture the class as DECODE is entered so the illegal-skip pulse in DECODE
          // is itself decoded from a register.
          state_d = StDecode;
          cls_d   = dec_cls;
        end
        StDecode: state_d = (cls_q == ILL) ? StFetch : StExec;
        StExec: begin
          if (final_cyc) begin
            state_d = StFetch;
          end else if (cls_q inside {LW, SW}) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem:   state_d = final_cyc ? StFetch : StWb;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (final_cyc && (cls_q != ILL)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    if (STICKY_ILLEGAL) begin
      illegal_d = illegal_q | ill_decode;
    end else begin
      illegal_d = ill_decode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      state_q   <= StFetch;
      cls_q     <= NOP;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      state_q   <= state_d;
      cls_q     <= cls_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ir_en    = run_q && (state_q == StFetch);
    pc_en    = final_cyc;
    RegWrite = final_cyc && writes_reg(cls_q);
    MemWrite = run_q && (state_q == StMem) && (cls_q == SW);
  end

  // Selects are held from EXEC through the final state and parked at 0 elsewhere.
  always_comb begin
    RegDst   = RegDstRd;
    NPCop    = NpcPc4;
    MemToReg = MemToRegAlu;
    ALUSrc   = AluSrcRd2;
    Extop    = ExtZero;
    ALUop    = AluAddu;
    if (sel_active) begin
      case (cls_q)
        RTYPE_ADDU: ALUop = AluAddu;
        RTYPE_SUBU: ALUop = AluSubu;
        ORI: begin
          RegDst = RegDstRt;
          ALUSrc = AluSrcExt;
          Extop  = ExtZero;
          ALUop  = AluOr;
        end
        LUI: begin
          RegDst = RegDstRt;
          ALUSrc = AluSrcExt;
          Extop  = ExtLui;
          ALUop  = AluOr;
        end
        LW: begin
          RegDst   = RegDstRt;
          MemToReg = MemToRegDm;
          ALUSrc   = AluSrcExt;
          Extop    = ExtSign;
          ALUop    = AluAddu;
        end
        SW: begin
          ALUSrc = AluSrcExt;
          Extop  = ExtSign;
          ALUop  = AluAddu;
        end
        BEQ: begin
          NPCop  = NpcBeq;
          ALUSrc = AluSrcRd2;
          ALUop  = AluSubu;
        end
        J:  NPCop = NpcJump;
        JAL: begin
          NPCop    = NpcJump;
          RegDst   = RegDstRa;
          MemToReg = MemToRegPc4;
        end
        JR:      NPCop = NpcJr;
        default: NPCop = NpcPc4;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios followed by random instruction
// streams, all checked cycle by cycle against a per-class timing model.
module tb_mc_controller;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    func;

  logic          ir_en, pc_en, reg_write, mem_write, illegal;
  logic [2:0]    reg_dst, npc_op, mem_to_reg, alu_src, state;
  logic [1:0]    ext_op, alu_op;
  logic [CW-1:0] instr_count;

  logic          p_ir_en, p_pc_en, p_reg_write, p_mem_write, p_illegal;
  logic [2:0]    p_reg_dst, p_npc_op, p_mem_to_reg, p_alu_src, p_state;
  logic [1:0]    p_ext_op, p_alu_op;
  logic [CW-1:0] p_instr_count;

  mc_controller #(.COUNT_WIDTH(CW), .STICKY_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .OPCODE(opcode), .FUNC(func),
    .ir_en(ir_en), .pc_en(pc_en), .RegDst(reg_dst), .NPCop(npc_op), .MemToReg(mem_to_reg),
    .RegWrite(reg_write), .MemWrite(mem_write), .ALUSrc(alu_src), .Extop(ext_op),
    .ALUop(alu_op), .state(state), .instr_count(instr_count), .illegal(illegal)
  );

  mc_controller #(.COUNT_WIDTH(CW), .STICKY_ILLEGAL(1'b0)) dut_pulse (
    .clk(clk), .reset(reset), .OPCODE(opcode), .FUNC(func),
    .ir_en(p_ir_en), .pc_en(p_pc_en), .RegDst(p_reg_dst), .NPCop(p_npc_op),
    .MemToReg(p_mem_to_reg), .RegWrite(p_reg_write), .MemWrite(p_mem_write),
    .ALUSrc(p_alu_src), .Extop(p_ext_op), .ALUop(p_alu_op), .state(p_state),
    .instr_count(p_instr_count), .illegal(p_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR,
                    C_NOP, C_ILL} kind_t;

  typedef struct packed {
    logic [2:0] regdst;
    logic [2:0] npc;
    logic [2:0] m2r;
    logic [2:0] alusrc;
    logic [1:0] ext;
    logic [1:0] aluop;
    logic       rw;
  } sel_t;

  int checks = 0;
  int errors = 0;
  int pc_seen = 0;
  int exp_count = 0;
  bit exp_ill = 1'b0;
  bit exp_pulse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return C_ADDU;
      if (fn == 6'b100011) return C_SUBU;
      if (fn == 6'b001000) return C_JR;
      if (fn == 6'b000000) return C_NOP;
      return C_ILL;
    end
    case (op)
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int n_cycles(input kind_t k);
    case (k)
      C_ADDU, C_SUBU, C_ORI, C_LUI, C_SW: return 4;
      C_LW:  return 5;
      C_ILL: return 2;
      default: return 3;
    endcase
  endfunction

  // Cycle i of an instruction: 0..2 are F,D,E; the 4th is MEM for loads/stores else WB.
  function automatic int state_at(input kind_t k, input int i);
    if (i < 3) return i;
    if (i == 3 && (k == C_LW || k == C_SW)) return 3;
    return 4;
  endfunction

  function automatic sel_t sel_of(input kind_t k);
    sel_t s = '0;
    case (k)
      C_ADDU: s.rw = 1'b1;
      C_SUBU: begin s.aluop = 2'd1; s.rw = 1'b1; end
      C_ORI:  begin s.regdst = 3'd1; s.alusrc = 3'd1; s.aluop = 2'd2; s.rw = 1'b1; end
      C_LUI:  begin s.regdst = 3'd1; s.alusrc = 3'd1; s.ext = 2'd2; s.aluop = 2'd2;
                    s.rw = 1'b1; end
      C_LW:   begin s.regdst = 3'd1; s.m2r = 3'd1; s.alusrc = 3'd1; s.ext = 2'd1;
                    s.rw = 1'b1; end
      C_SW:   begin s.alusrc = 3'd1; s.ext = 2'd1; end
      C_BEQ:  begin s.npc = 3'd1; s.aluop = 2'd1; end
      C_J:    s.npc = 3'd2;
      C_JAL:  begin s.npc = 3'd2; s.regdst = 3'd2; s.m2r = 3'd2; s.rw = 1'b1; end
      C_JR:   s.npc = 3'd3;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic check_cycle(input kind_t k, input int i);
    int   n    = n_cycles(k);
    bit   last = (i == n - 1);
    bit   act  = (i >= 2);
    sel_t s    = act ? sel_of(k) : '0;
    chk("state", 32'(state), 32'(state_at(k, i)));
    chk("ir_en", 32'(ir_en), 32'(i == 0));
    chk("pc_en", 32'(pc_en), 32'(last));
    chk("NPCop", 32'(npc_op), 32'(s.npc));
    chk("RegWrite", 32'(reg_write), 32'(last && s.rw));
    chk("MemWrite", 32'(mem_write), 32'(k == C_SW && state_at(k, i) == 3));
    chk("RegDst", 32'(reg_dst), 32'(s.regdst));
    chk("MemToReg", 32'(mem_to_reg), 32'(s.m2r));
    chk("ALUSrc", 32'(alu_src), 32'(s.alusrc));
    chk("Extop", 32'(ext_op), 32'(s.ext));
    chk("ALUop", 32'(alu_op), 32'(s.aluop));
    chk("instr_count", 32'(instr_count), 32'(exp_count));
    chk("illegal_sticky", 32'(illegal), 32'(exp_ill));
    chk("illegal_pulse", 32'(p_illegal), 32'(exp_pulse));
    chk("state_pulse_inst", 32'(p_state), 32'(state_at(k, i)));
    if (pc_en === 1'b1) pc_seen++;
  endtask

  task automatic advance(input kind_t k, input int i);
    @(posedge clk);
    #1;
    exp_pulse = (k == C_ILL && i == 1);
    if (exp_pulse) exp_ill = 1'b1;
    if (i == n_cycles(k) - 1 && k != C_ILL) exp_count = (exp_count + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    kind_t k = classify(op, fn);
    opcode = op;
    func   = fn;
    for (int i = 0; i < n_cycles(k); i++) begin
      check_cycle(k, i);
      advance(k, i);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_ir_en"}, 32'(ir_en), 32'd0);
    chk({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    chk({tag, "_RegWrite"}, 32'(reg_write), 32'd0);
    chk({tag, "_MemWrite"}, 32'(mem_write), 32'd0);
    chk({tag, "_selects"}, {18'd0, reg_dst, npc_op, mem_to_reg, alu_src, ext_op}, 32'd0);
    chk({tag, "_ALUop"}, 32'(alu_op), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_illegal_p"}, 32'(p_illegal), 32'd0);
  endtask

  // Release reset between edges and move to the first live FETCH cycle.
  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("release_cycle");
    @(posedge clk);
    #1;
    exp_count = 0;
    exp_ill   = 1'b0;
    exp_pulse = 1'b0;
  endtask

  logic [5:0] legal_op [11] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101,
                                6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                6'b000011};
  logic [5:0] legal_fn [11] = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000};

  initial begin
    int pc_base;
    int sel;
    logic [5:0] rop;
    logic [5:0] rfn;

    reset  = 1'b1;
    opcode = 6'b0;
    func   = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("in_reset");
    release_reset();

    // addu: F,D,E,W with count 0 -> 1
    run_instr(6'b000000, 6'b100001);
    chk("addu_count", 32'(instr_count), 32'd1);

    run_instr(6'b100011, 6'b000000);
    run_instr(6'b101011, 6'b000000);
    run_instr(6'b000011, 6'b000000);
    chk("jal_count", 32'(instr_count), 32'd4);

    // Illegal opcode, then addu: sticky flag survives, pulse flag is gone.
    run_instr(6'b111111, 6'b000000);
    chk("ill_count_unchanged", 32'(instr_count), 32'd4);
    chk("ill_flag_set", 32'(illegal), 32'd1);
    run_instr(6'b000000, 6'b100001);
    chk("ill_sticky_after_addu", 32'(illegal), 32'd1);
    chk("ill_pulse_cleared", 32'(p_illegal), 32'd0);

    // Abort lw in EXEC with an asynchronous reset between edges.
    opcode = 6'b100011;
    func   = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      check_cycle(C_LW, i);
      if (i < 2) advance(C_LW, i);
    end
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_reset_lw");
    release_reset();

    // 16 nops wrap a 4-bit counter back to 0 with exactly 16 pc_en pulses.
    pc_base = pc_seen;
    for (int n = 0; n < 16; n++) begin
      run_instr(6'b000000, 6'b000000);
      if (n == 14) chk("nop_count_15", 32'(instr_count), 32'd15);
    end
    chk("nop_wrap_count", 32'(instr_count), 32'd0);
    chk("nop_pc_en_pulses", 32'(pc_seen - pc_base), 32'd16);

    // Random instruction stream, legal and illegal encodings mixed.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 13);
      if (sel < 11) begin
        rop = legal_op[sel];
        rfn = legal_fn[sel];
      end else if (sel == 11) begin
        rop = 6'b000000;
        rfn = 6'($urandom);
      end else begin
        rop = 6'($urandom);
        rfn = 6'($urandom);
      end
      run_instr(rop, rfn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
